// File: rtl/ptw_tb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ptw_tb_pkg
// Brief   : Shared types for the PTW data-cache request port and the
//           page-table memory responder state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package ptw_tb_pkg;

    localparam int riscv_PLEN = 34;
    localparam int PPNW       = 22;

    // Request from the page-table walker, MSB first.
    typedef struct packed {
        logic [11:0]     address_index;
        logic [PPNW-1:0] address_tag;
        logic [31:0]     data_wdata;
        logic [0:0]      data_wuser;
        logic            data_req;
        logic            data_we;
        logic [3:0]      data_be;
        logic [1:0]      data_size;
        logic            kill_req;
        logic            tag_valid;
    } dcache_req_i_t;

    // Response to the page-table walker, MSB first.
    typedef struct packed {
        logic        data_gnt;
        logic        data_rvalid;
        logic [31:0] data_rdata;
        logic [0:0]  data_ruser;
    } dcache_req_o_t;

    // Bit offsets (LSB position) of the request fields.
    localparam int REQ_TAG_VALID_LSB = 0;
    localparam int REQ_KILL_LSB      = 1;
    localparam int REQ_SIZE_LSB      = 2;
    localparam int REQ_BE_LSB        = 4;
    localparam int REQ_WE_LSB        = 8;
    localparam int REQ_REQ_LSB       = 9;
    localparam int REQ_WUSER_LSB     = 10;
    localparam int REQ_WDATA_LSB     = 11;
    localparam int REQ_TAG_LSB       = 43;
    localparam int REQ_INDEX_LSB     = 65;
    localparam int REQ_WIDTH         = 77;

    // Bit offsets (LSB position) of the response fields.
    localparam int RSP_RUSER_LSB  = 0;
    localparam int RSP_RDATA_LSB  = 1;
    localparam int RSP_RVALID_LSB = 33;
    localparam int RSP_GNT_LSB    = 34;
    localparam int RSP_WIDTH      = 35;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GNT_WAIT = 3'd1,
        ST_TAG      = 3'd2,
        ST_LAT      = 3'd3,
        ST_RESP     = 3'd4
    } pt_resp_state_e;

    // Word address of a physical address built from the two request phases.
    function automatic logic [31:0] paddr_word(input logic [PPNW-1:0] tag,
                                               input logic [11:0]     index);
        logic [riscv_PLEN-1:0] paddr;
        paddr      = {tag, index};
        paddr_word = paddr[riscv_PLEN-1:2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ptw_pt_mem.sv
`default_nettype none
// ============================================================================
// Module  : ptw_pt_mem
// Brief   : Word RAM holding PTEs. One read/write port with byte enables,
//           asynchronous read, plus an independent preload write port that
//           takes priority on a same-word collision.
// Revision: 1.0 - initial release
// ============================================================================
module ptw_pt_mem #(
    parameter  int DEPTH_WORDS = 1024,
    localparam int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [3:0]    be_i,
    input  logic [31:0]   wdata_i,
    input  logic          init_we_i,
    input  logic [AW-1:0] init_addr_i,
    input  logic [31:0]   init_data_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem [DEPTH_WORDS];

    // Byte-enabled port write, then preload write; the later assignment wins.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
        if (init_we_i) begin
            mem[init_addr_i] <= init_data_i;
        end
    end

    assign rdata_o = mem[addr_i];

endmodule
`default_nettype wire

// File: rtl/ptw_pt_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : ptw_pt_mem_responder
// Brief   : Stand-in for the L1 D-cache on the sv32 PTW request port. Serves
//           PTE reads and byte-enabled writes from a preloadable word RAM with
//           configurable grant delay and read latency; supports kill_req.
// Revision: 1.0 - initial release
// ============================================================================
module ptw_pt_mem_responder
    import ptw_tb_pkg::*;
#(
    parameter  int              DEPTH_WORDS = 1024,
    parameter  logic [PPNW-1:0] BASE_PPN    = '0,
    parameter  int              GNT_DELAY   = 0,
    parameter  int              RD_LATENCY  = 1,
    localparam int              AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  dcache_req_i_t req_port_i,
    output dcache_req_o_t req_port_o,
    input  logic          init_we_i,
    input  logic [AW-1:0] init_addr_i,
    input  logic [31:0]   init_data_i,
    output logic          oob_o,
    output logic [15:0]   req_cnt_o,
    output logic [15:0]   kill_cnt_o
);

    pt_resp_state_e  state_q, state_d;
    logic [15:0]     gcnt_q, gcnt_d;
    logic [15:0]     lcnt_q, lcnt_d;
    logic [11:0]     index_q, index_d;
    logic [PPNW-1:0] tag_q, tag_d;
    logic            we_q, we_d;
    logic [3:0]      be_q, be_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            rvalid_q, rvalid_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            oob_q, oob_d;
    logic [15:0]     req_cnt_q, req_cnt_d;
    logic [15:0]     kill_cnt_q, kill_cnt_d;

    logic            w_gnt;
    logic            w_kill;
    logic            w_mem_we;
    logic [PPNW-1:0] w_tag_sel;
    logic [31:0]     w_word;
    logic [31:0]     w_off;
    logic            w_in_win;
    logic [31:0]     w_mem_rdata;
    logic            w_unused;

    // The tag is live on the tag cycle and held afterwards for later reads.
    assign w_tag_sel = (state_q == ST_TAG) ? req_port_i.address_tag : tag_q;
    assign w_word    = paddr_word(w_tag_sel, index_q);
    // Unsigned wrap makes addresses below the window look huge, so one compare suffices.
    assign w_off     = w_word - {BASE_PPN, 10'b0};
    assign w_in_win  = (w_off < 32'(DEPTH_WORDS));

    ptw_pt_mem #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_mem (
        .clk_i       (clk_i),
        .we_i        (w_mem_we),
        .addr_i      (w_off[AW-1:0]),
        .be_i        (be_q),
        .wdata_i     (wdata_q),
        .init_we_i   (init_we_i && (state_q == ST_IDLE)),
        .init_addr_i (init_addr_i),
        .init_data_i (init_data_i),
        .rdata_o     (w_mem_rdata)
    );

    // Next-state, grant, kill and response computation for the two-phase handshake.
    always_comb begin
        state_d    = state_q;
        gcnt_d     = gcnt_q;
        lcnt_d     = lcnt_q;
        index_d    = index_q;
        tag_d      = tag_q;
        we_d       = we_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        w_gnt      = 1'b0;
        w_kill     = 1'b0;
        w_mem_we   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_port_i.data_req) begin
                    if (GNT_DELAY == 0) begin
                        w_gnt   = 1'b1;
                        state_d = ST_TAG;
                    end else begin
                        gcnt_d  = 16'(GNT_DELAY - 1);
                        state_d = ST_GNT_WAIT;
                    end
                end
            end
            ST_GNT_WAIT: begin
                if (!req_port_i.data_req) begin
                    state_d = ST_IDLE;
                end else if (gcnt_q == 16'd0) begin
                    w_gnt   = 1'b1;
                    state_d = ST_TAG;
                end else begin
                    gcnt_d = gcnt_q - 16'd1;
                end
            end
            ST_TAG: begin
                if (req_port_i.kill_req) begin
                    w_kill  = 1'b1;
                    state_d = ST_IDLE;
                end else if (req_port_i.tag_valid) begin
                    tag_d = req_port_i.address_tag;
                    if (we_q) begin
                        w_mem_we = w_in_win;
                        state_d  = ST_IDLE;
                    end else if (RD_LATENCY <= 1) begin
                        state_d = ST_RESP;
                    end else begin
                        lcnt_d  = 16'(RD_LATENCY - 1);
                        state_d = ST_LAT;
                    end
                end
            end
            ST_LAT: begin
                if (req_port_i.kill_req) begin
                    w_kill  = 1'b1;
                    state_d = ST_IDLE;
                end else if (lcnt_q <= 16'd1) begin
                    state_d = ST_RESP;
                end else begin
                    lcnt_d = lcnt_q - 16'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_gnt) begin
            index_d = req_port_i.address_index;
            we_d    = req_port_i.data_we;
            be_d    = req_port_i.data_be;
            wdata_d = req_port_i.data_wdata;
        end

        // Response registers are loaded on entry to RESP so they line up with it.
        rvalid_d = (state_d == ST_RESP);
        rdata_d  = (state_d == ST_RESP && w_in_win) ? w_mem_rdata : 32'h0;
        oob_d    = (state_d == ST_RESP) && !w_in_win;

        req_cnt_d  = (w_gnt && req_cnt_q != 16'hFFFF)   ? req_cnt_q + 16'd1  : req_cnt_q;
        kill_cnt_d = (w_kill && kill_cnt_q != 16'hFFFF) ? kill_cnt_q + 16'd1 : kill_cnt_q;
    end

    // All state and output registers; reset drops any transaction in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            gcnt_q     <= '0;
            lcnt_q     <= '0;
            index_q    <= '0;
            tag_q      <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            oob_q      <= 1'b0;
            req_cnt_q  <= '0;
            kill_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gcnt_q     <= gcnt_d;
            lcnt_q     <= lcnt_d;
            index_q    <= index_d;
            tag_q      <= tag_d;
            we_q       <= we_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            oob_q      <= oob_d;
            req_cnt_q  <= req_cnt_d;
            kill_cnt_q <= kill_cnt_d;
        end
    end

    assign req_port_o.data_gnt    = w_gnt;
    assign req_port_o.data_rvalid = rvalid_q;
    assign req_port_o.data_rdata  = rdata_q;
    assign req_port_o.data_ruser  = 1'b0;
    assign oob_o                  = oob_q;
    assign req_cnt_o              = req_cnt_q;
    assign kill_cnt_o             = kill_cnt_q;

    // Only full words are served and the user bit is not stored.
    assign w_unused = ^{req_port_i.data_wuser, req_port_i.data_size};

endmodule
`default_nettype wire
